// File: rtl/dsp_fft_frame_feeder.sv
// Frame feeder for dsp_ite_fft: gathers a gappy sample stream into ping-pong frames
// and replays each frame as a gap-free FFT_N-cycle burst while the FFT is not busy.
module dsp_fft_frame_feeder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FFT_N  = 8,
  parameter int unsigned LOG2N  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*DATA_W-1:0] s_din,
  input  logic                s_vld,
  output logic                s_ovf,
  output logic [2*DATA_W-1:0] m_dout,
  output logic                m_vld,
  input  logic                m_busy
);

  localparam int unsigned SW = 2 * DATA_W;

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state;
  logic [SW-1:0]        mem [2][FFT_N];
  logic [1:0]           full;
  logic                 wr_bank;
  logic                 rd_bank;
  logic [LOG2N-1:0]     wr_idx;
  logic [LOG2N-1:0]     rd_idx;

  logic                 wr_en_c;
  logic                 wr_last_c;
  logic                 burst_end_c;
  logic                 nxt_bank_c;
  logic [1:0]           fill_c;
  logic [1:0]           clr_c;
  logic [1:0]           avail_c;

  // A bank completing on this edge may start a burst on the same edge; drops use the pre-edge flag.
  always_comb begin
    wr_en_c     = s_vld && !full[wr_bank];
    wr_last_c   = (wr_idx == LOG2N'(FFT_N - 1));
    burst_end_c = (state == BURST) && (rd_idx == '0);
    nxt_bank_c  = ~rd_bank;
    fill_c      = '0;
    clr_c       = '0;
    if (wr_en_c && wr_last_c) fill_c[wr_bank] = 1'b1;
    if (burst_end_c)          clr_c[rd_bank]  = 1'b1;
    avail_c     = full | fill_c;
  end

  // Sample storage; validity is tracked solely by the full flags.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_bank][wr_idx] <= s_din;
  end

  // Write side: index/bank advance, full flags and overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
      full    <= '0;
      s_ovf   <= 1'b0;
    end else begin
      s_ovf <= s_vld && full[wr_bank];
      full  <= (full & ~clr_c) | fill_c;
      if (wr_en_c) begin
        if (wr_last_c) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx  <= wr_idx + LOG2N'(1);
        end
      end
    end
  end

  // Read FSM; rd_idx wrapping to zero inside BURST marks the end-of-frame edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
      rd_idx  <= '0;
      m_dout  <= '0;
      m_vld   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (avail_c[rd_bank] && !m_busy) begin
            state  <= BURST;
            m_dout <= mem[rd_bank][0];
            m_vld  <= 1'b1;
            rd_idx <= LOG2N'(1);
          end
        end
        BURST: begin
          if (rd_idx != '0) begin
            m_dout <= mem[rd_bank][rd_idx];
            rd_idx <= rd_idx + LOG2N'(1);
          end else begin
            rd_bank <= nxt_bank_c;
            if (avail_c[nxt_bank_c] && !m_busy) begin
              m_dout <= mem[nxt_bank_c][0];
              rd_idx <= LOG2N'(1);
            end else begin
              m_vld  <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
